aes_engine_arbiter: RTL and testbench

AES_ENGINE_ARBITER -- requirements
Module: aes_engine_arbiter

---
 rtl/aes_engine_arbiter.sv | 168 ++++++++++++++++
 tb/tb_aes_engine_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_engine_arbiter.sv
// Round-robin arbiter sharing one combinational AES engine between two requesters.
// Optional macro AES_ARB_KEYSIZE_CHECK_EN: bits=3 requests are answered at once with rsp_err=1.
module aes_engine_arbiter #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_bits,
  input  logic         req0_decrypt,
  input  logic [127:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_bits,
  input  logic         req1_decrypt,
  input  logic [127:0] req1_data,
  output logic [1:0]   eng_bits,
  output logic         eng_decrypt,
  output logic [127:0] eng_data,
  input  logic [127:0] eng_result,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  input  logic         rsp_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           last_grant_q, last_grant_d;
  logic           id_q, id_d;
  logic [1:0]     eng_bits_q, eng_bits_d;
  logic           eng_decrypt_q, eng_decrypt_d;
  logic [127:0]   eng_data_q, eng_data_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
`ifdef AES_ARB_KEYSIZE_CHECK_EN
  logic           rsp_err_q, rsp_err_d;
`endif

  logic           grant;
  logic           take;
  logic [1:0]     sel_bits;
  logic           sel_decrypt;
  logic [127:0]   sel_data;

  // Lone requester wins; on contention the one not granted last wins.
  always_comb begin
    grant = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
  end

  assign take        = (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready  = take && !grant;
  assign req1_ready  = take && grant;
  assign sel_bits    = grant ? req1_bits    : req0_bits;
  assign sel_decrypt = grant ? req1_decrypt : req0_decrypt;
  assign sel_data    = grant ? req1_data    : req0_data;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    eng_bits_d    = eng_bits_q;
    eng_decrypt_d = eng_decrypt_q;
    eng_data_d    = eng_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
`ifdef AES_ARB_KEYSIZE_CHECK_EN
    rsp_err_d     = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (take) begin
          last_grant_d = grant;
          id_d         = grant;
`ifdef AES_ARB_KEYSIZE_CHECK_EN
          // Illegal key size bypasses the engine and leaves its operands untouched.
          if (sel_bits == 2'd3) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else
`endif
          begin
            eng_bits_d    = sel_bits;
            eng_decrypt_d = sel_decrypt;
            eng_data_d    = sel_data;
            cnt_d         = 8'(WAIT_CYCLES - 1);
            state_d       = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = eng_result;
`ifdef AES_ARB_KEYSIZE_CHECK_EN
          rsp_err_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      id_q          <= 1'b0;
      eng_bits_q    <= '0;
      eng_decrypt_q <= 1'b0;
      eng_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
`ifdef AES_ARB_KEYSIZE_CHECK_EN
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      eng_bits_q    <= eng_bits_d;
      eng_decrypt_q <= eng_decrypt_d;
      eng_data_q    <= eng_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
`ifdef AES_ARB_KEYSIZE_CHECK_EN
      rsp_err_q     <= rsp_err_d;
`endif
    end
  end

  assign eng_bits    = eng_bits_q;
  assign eng_decrypt = eng_decrypt_q;
  assign eng_data    = eng_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_data    = rsp_data_q;
`ifdef AES_ARB_KEYSIZE_CHECK_EN
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_aes_engine_arbiter.sv
// Directed bench for aes_engine_arbiter: default instance plus a WAIT_CYCLES=1 instance.
module tb_aes_engine_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;

  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_bits = '0, req1_bits = '0;
  logic         req0_decrypt = 1'b0, req1_decrypt = 1'b0;
  logic [127:0] req0_data = '0, req1_data = '0;
  logic [1:0]   eng_bits;
  logic         eng_decrypt;
  logic [127:0] eng_data, eng_result;
  logic         rsp_valid, rsp_id, rsp_err;
  logic [127:0] rsp_data;
  logic         rsp_ready = 1'b1;

  logic         b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic         b_req0_ready, b_req1_ready;
  logic [1:0]   b_req0_bits = '0, b_req1_bits = '0;
  logic         b_req0_decrypt = 1'b0, b_req1_decrypt = 1'b0;
  logic [127:0] b_req0_data = '0, b_req1_data = '0;
  logic [1:0]   b_eng_bits;
  logic         b_eng_decrypt;
  logic [127:0] b_eng_data, b_eng_result;
  logic         b_rsp_valid, b_rsp_id, b_rsp_err;
  logic [127:0] b_rsp_data;
  logic         b_rsp_ready = 1'b1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [127:0] D_VEC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] A_VEC = 128'h0123456789abcdef0f1e2d3c4b5a6978;
  localparam logic [127:0] B_VEC = 128'hfedcba98765432100011223344556677;
  localparam logic [127:0] E_VEC = 128'hdeadbeefcafef00d1234567890abcdef;
  localparam logic [127:0] F_VEC = 128'h13579bdf2468ace013579bdf2468ace0;
  localparam logic [127:0] G_VEC = 128'h55555555aaaaaaaa33333333cccccccc;
  localparam logic [127:0] H0_VEC = 128'h0badc0de0badc0de0badc0de0badc0de;
  localparam logic [127:0] H1_VEC = 128'h1111222233334444555566667777888;
  localparam logic [127:0] K_VEC = 128'h99887766554433221100ffeeddccbbaa;
  localparam logic [127:0] L_VEC = 128'h7777777788888888999999990000000f;

  // Stand-in for the AES datapath: any key/mode/data-dependent mapping suffices.
  function automatic logic [127:0] model(input logic [1:0] b, input logic d, input logic [127:0] x);
    return {x[95:0], x[127:96]} ^ {32{b, d, 1'b1}};
  endfunction

  assign eng_result   = model(eng_bits, eng_decrypt, eng_data);
  assign b_eng_result = model(b_eng_bits, b_eng_decrypt, b_eng_data);

  always #5 clock = ~clock;

  aes_engine_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_bits(req0_bits),
    .req0_decrypt(req0_decrypt), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_bits(req1_bits),
    .req1_decrypt(req1_decrypt), .req1_data(req1_data),
    .eng_bits(eng_bits), .eng_decrypt(eng_decrypt), .eng_data(eng_data),
    .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready)
  );

  aes_engine_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_bits(b_req0_bits),
    .req0_decrypt(b_req0_decrypt), .req0_data(b_req0_data),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_bits(b_req1_bits),
    .req1_decrypt(b_req1_decrypt), .req1_data(b_req1_data),
    .eng_bits(b_eng_bits), .eng_decrypt(b_eng_decrypt), .eng_data(b_eng_data),
    .eng_result(b_eng_result),
    .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
    .rsp_ready(b_rsp_ready)
  );

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id got %0b want 0", rsp_id); else pass_cnt++;
    total_cnt++; if (rsp_data !== '0) $display("FAIL reset_rsp_data got %h want 0", rsp_data); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %0b want 0", rsp_err); else pass_cnt++;
    total_cnt++; if ({eng_bits, eng_decrypt, eng_data} !== '0)
      $display("FAIL reset_eng got bits=%0d dec=%0b data=%h want all 0", eng_bits, eng_decrypt, eng_data); else pass_cnt++;
    total_cnt++; if (b_rsp_valid !== 1'b0) $display("FAIL reset_w1_rsp_valid got %0b want 0", b_rsp_valid); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic early;
    early = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_bits = 2'd0; req0_decrypt = 1'b0; req0_data = D_VEC;
    #1;
    total_cnt++; if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL single_ready got %b want 01", {req1_ready, req0_ready}); else pass_cnt++;
    @(posedge clock); #1;
    req0_valid = 1'b0;
    total_cnt++; if ({eng_bits, eng_decrypt, eng_data} !== {2'd0, 1'b0, D_VEC})
      $display("FAIL single_eng_latch got %h want %h", eng_data, D_VEC); else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock); #1;
      early = early | rsp_valid;
    end
    total_cnt++; if (early !== 1'b0) $display("FAIL single_early_valid got 1 want 0"); else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL single_latency got valid=%0b want 1", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_id !== 1'b0) $display("FAIL single_id got %0b want 0", rsp_id); else pass_cnt++;
    total_cnt++; if (rsp_data !== model(2'd0, 1'b0, D_VEC))
      $display("FAIL single_data got %h want %h", rsp_data, model(2'd0, 1'b0, D_VEC)); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b0) $display("FAIL single_err got %0b want 0", rsp_err); else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL single_drop_valid got %0b want 0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic         g[3];
    int           gc[3];
    logic         rid[3];
    logic [127:0] rdat[3];
    int           ng, nr;
    logic         both;
    ng = 0; nr = 0; both = 1'b0;
    for (int i = 0; i < 3; i++) begin g[i] = 1'bx; gc[i] = 0; rid[i] = 1'bx; rdat[i] = 'x; end
    apply_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_bits = 2'd1; req0_decrypt = 1'b0; req0_data = A_VEC;
    req1_valid = 1'b1; req1_bits = 2'd2; req1_decrypt = 1'b1; req1_data = B_VEC;
    for (int c = 0; c < 60 && nr < 3; c++) begin
      #1;
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_ready || req1_ready) begin
        if (ng < 3) begin g[ng] = req1_ready; gc[ng] = c; end
        ng++;
      end
      @(posedge clock); #1;
      if (rsp_valid) begin
        if (nr < 3) begin rid[nr] = rsp_id; rdat[nr] = rsp_data; end
        nr++;
      end
      if (ng >= 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total_cnt++; if (nr != 3) $display("FAIL rr_response_count got %0d want 3", nr); else pass_cnt++;
    total_cnt++; if (both !== 1'b0) $display("FAIL rr_both_ready got 1 want 0"); else pass_cnt++;
    total_cnt++; if ({g[0], g[1], g[2]} !== 3'b010)
      $display("FAIL rr_grant_order got %b want 010", {g[0], g[1], g[2]}); else pass_cnt++;
    total_cnt++; if ({rid[0], rid[1], rid[2]} !== 3'b010)
      $display("FAIL rr_rsp_ids got %b want 010", {rid[0], rid[1], rid[2]}); else pass_cnt++;
    total_cnt++; if (rdat[0] !== model(2'd1, 1'b0, A_VEC) || rdat[2] !== model(2'd1, 1'b0, A_VEC))
      $display("FAIL rr_data_req0 got %h,%h want %h", rdat[0], rdat[2], model(2'd1, 1'b0, A_VEC)); else pass_cnt++;
    total_cnt++; if (rdat[1] !== model(2'd2, 1'b1, B_VEC))
      $display("FAIL rr_data_req1 got %h want %h", rdat[1], model(2'd2, 1'b1, B_VEC)); else pass_cnt++;
    total_cnt++; if (gc[1] - gc[0] != 6 || gc[2] - gc[1] != 6)
      $display("FAIL rr_throughput got spacing %0d,%0d want 6,6", gc[1] - gc[0], gc[2] - gc[1]); else pass_cnt++;
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure();
    int bad, cnt;
    logic id1;
    logic [127:0] d1;
    bad = 0; cnt = 0; id1 = 1'bx; d1 = 'x;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_bits = 2'd2; req0_decrypt = 1'b1; req0_data = E_VEC;
    @(posedge clock); #1;
    req0_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin @(posedge clock); #1; end
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_wait_valid got %0b want 1", rsp_valid); else pass_cnt++;
    req1_valid = 1'b1; req1_bits = 2'd0; req1_decrypt = 1'b0; req1_data = F_VEC;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== model(2'd2, 1'b1, E_VEC) ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
      @(posedge clock); #1;
    end
    total_cnt++; if (bad != 0) $display("FAIL bp_hold_stable got %0d bad cycles want 0", bad); else pass_cnt++;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_release got valid=%0b want 0", rsp_valid); else pass_cnt++;
    #1;
    total_cnt++; if ({req1_ready, req0_ready} !== 2'b10)
      $display("FAIL bp_pending_grant got %b want 10", {req1_ready, req0_ready}); else pass_cnt++;
    @(posedge clock); #1;
    req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (rsp_valid) begin cnt++; id1 = rsp_id; d1 = rsp_data; end
    end
    total_cnt++; if (cnt != 1 || id1 !== 1'b1)
      $display("FAIL bp_followup_rsp got count=%0d id=%0b want 1 id=1", cnt, id1); else pass_cnt++;
    total_cnt++; if (d1 !== model(2'd0, 1'b0, F_VEC))
      $display("FAIL bp_followup_data got %h want %h", d1, model(2'd0, 1'b0, F_VEC)); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_bits = 2'd1; req0_decrypt = 1'b1; req0_data = G_VEC;
    @(posedge clock); #1;
    req0_valid = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    #1;
    total_cnt++; if (eng_data !== '0 || rsp_valid !== 1'b0)
      $display("FAIL midrst_async got eng_data=%h valid=%0b want 0,0", eng_data, rsp_valid); else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clock); #1; if (rsp_valid) seen++; end
    total_cnt++; if (seen != 0) $display("FAIL midrst_no_rsp got %0d responses want 0", seen); else pass_cnt++;
    req0_valid = 1'b1; req0_bits = 2'd0; req0_decrypt = 1'b0; req0_data = H0_VEC;
    req1_valid = 1'b1; req1_bits = 2'd2; req1_decrypt = 1'b0; req1_data = H1_VEC;
    #1;
    total_cnt++; if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL midrst_first_grant got %b want 01", {req1_ready, req0_ready}); else pass_cnt++;
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clock); #1; end
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== model(2'd0, 1'b0, H0_VEC))
      $display("FAIL midrst_next_rsp got valid=%0b id=%0b data=%h want 1,0,%h",
               rsp_valid, rsp_id, rsp_data, model(2'd0, 1'b0, H0_VEC)); else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin @(posedge clock); #1; if (rsp_valid) seen++; end
    total_cnt++; if (seen != 0) $display("FAIL dropped_req_rsp got %0d responses want 0", seen); else pass_cnt++;
  endtask

  task automatic test_keysize();
    logic early;
    early = 1'b0;
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_bits = 2'd3; req1_decrypt = 1'b1; req1_data = K_VEC;
    #1;
    total_cnt++; if (req1_ready !== 1'b1) $display("FAIL ks_ready got %0b want 1", req1_ready); else pass_cnt++;
    @(posedge clock); #1;
    req1_valid = 1'b0;
`ifdef AES_ARB_KEYSIZE_CHECK_EN
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1)
      $display("FAIL ks_fast_rsp got valid=%0b id=%0b want 1,1", rsp_valid, rsp_id); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b1 || rsp_data !== '0)
      $display("FAIL ks_err got err=%0b data=%h want 1,0", rsp_err, rsp_data); else pass_cnt++;
    total_cnt++; if (eng_data !== H0_VEC || eng_bits !== 2'd0)
      $display("FAIL ks_eng_hold got %h want %h", eng_data, H0_VEC); else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL ks_release got %0b want 0", rsp_valid); else pass_cnt++;
`else
    total_cnt++; if (eng_bits !== 2'd3 || eng_data !== K_VEC)
      $display("FAIL ks_eng_latch got bits=%0d data=%h want 3,%h", eng_bits, eng_data, K_VEC); else pass_cnt++;
    early = rsp_valid;
    for (int i = 1; i <= 3; i++) begin @(posedge clock); #1; early = early | rsp_valid; end
    total_cnt++; if (early !== 1'b0) $display("FAIL ks_early_valid got 1 want 0"); else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b0)
      $display("FAIL ks_normal_rsp got valid=%0b id=%0b err=%0b want 1,1,0", rsp_valid, rsp_id, rsp_err); else pass_cnt++;
    total_cnt++; if (rsp_data !== model(2'd3, 1'b1, K_VEC))
      $display("FAIL ks_normal_data got %h want %h", rsp_data, model(2'd3, 1'b1, K_VEC)); else pass_cnt++;
    @(posedge clock); #1;
`endif
  endtask

  task automatic test_back_to_back_w1();
    logic [11:0] gmask, rmask;
    int bad;
    gmask = '0; rmask = '0; bad = 0;
    b_rsp_ready = 1'b1;
    b_req0_valid = 1'b1; b_req0_bits = 2'd0; b_req0_decrypt = 1'b1; b_req0_data = L_VEC;
    for (int c = 0; c < 12; c++) begin
      #1;
      gmask[c] = b_req0_ready;
      @(posedge clock); #1;
      rmask[c] = b_rsp_valid;
      if (b_rsp_valid && b_rsp_data !== model(2'd0, 1'b1, L_VEC)) bad++;
    end
    b_req0_valid = 1'b0;
    total_cnt++; if (gmask !== 12'h249) $display("FAIL w1_grant_pattern got %b want %b", gmask, 12'h249); else pass_cnt++;
    total_cnt++; if (rmask !== 12'h492) $display("FAIL w1_rsp_pattern got %b want %b", rmask, 12'h492); else pass_cnt++;
    total_cnt++; if (bad != 0) $display("FAIL w1_rsp_data got %0d bad responses want 0", bad); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_keysize();
    test_back_to_back_w1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
